inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the core's instruction decoder.
- Accepts a field-level instruction request (kind, rs, rt, rd, imm) over a valid/ready handshake and emits the 32-bit MIPS-subset word with an auto-incrementing instruction-memory write address.
- Feeds the imem loader and self-checking benches, so the decoder path can be exercised from symbolic programs.

Parameters:
- AW, 10, instruction-memory word-address width.
- BASE, 0, word address loaded into the address counter at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_kind  in  4  kind_t: ADDIU, ANDI, BEQ, LW, SW, ADDU, AND, DIVU, MFHI, MFLO; other codes are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate / branch offset.
- addr_load  in  1  load address counter from addr_val; only honoured when no output is pending.
- addr_val  in  AW  new address.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_word  out  32  encoded instruction.
- out_addr  out  AW  word address for out_word.
- err_illegal  out  1  one-cycle pulse when an illegal kind is accepted.
- words_sent  out  AW  count of words transferred since reset, wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge) gives:
  - out_valid=0, out_word=0, out_addr=BASE
  - err_illegal=0, words_sent=0
  - FSM=EMPTY
  - any pending word or pad is discarded.
- Encodings (shamt always 0; unused fields 0):
  - I-type = {op, rs, rt, imm}. Opcodes: ADDIU 001001, ANDI 001100, BEQ 000100, LW 100011, SW 101011.
  - R-type = {000000, rs, rt, rd, 00000, funct}. Functs: ADDU 100001, AND 100100, DIVU 011010, MFHI 010000, MFLO 010010.
  - Field masking: DIVU forces rd=0; MFHI/MFLO force rs=rt=0.
- FSM states EMPTY, FULL, PAD.
  - EMPTY: in_ready=1. An accepted legal request loads out_word and goes to FULL.
  - FULL: out_valid=1. in_ready = out_ready (single-entry pipeline register, throughput 1 word/cycle).
    - Transfer with a simultaneous accept: reload, stay FULL.
    - Transfer without accept: go to EMPTY.
  - PAD: see Optional Feature. Without the macro, PAD is unreachable.
- Latency: accept at edge N gives out_valid at edge N (registered output visible in cycle N+1).
- Handshake rules:
  - out_word and out_addr stay stable while out_valid & !out_ready.
  - in_* may change freely when in_ready=0.
- Address and count:
  - On each transfer (out_valid & out_ready): out_addr increments by 1, wrapping at 2^AW-1 to 0; words_sent increments by 1, wrapping.
  - addr_load in EMPTY: out_addr = addr_val next cycle. In FULL/PAD it is ignored.
- Illegal kind:
  - Accepted (in_ready=1) but not emitted.
  - err_illegal=1 for the following cycle.
  - State and address are unchanged; no stall.

Optional Feature:
- Macro INST_ENCODER_DELAY_SLOT_EN.
- Defined: when a BEQ word transfers, the FSM enters PAD.
  - In PAD: in_ready=0, out_valid=1, out_word=0x00000000 (NOP), at out_addr = branch_addr+1.
  - A NOP transfer goes to EMPTY.
  - The pad counts in words_sent.
- Undefined: BEQ is treated like any other word; no pad.

Decomposition:
- Package leg_isa_pkg holds:
  - kind_t enum;
  - opcode and funct localparams (OP_ADDIU, OP_ANDI, OP_BEQ, OP_LW, OP_SW, OP_RTYPE, FN_ADDU, FN_AND, FN_DIVU, FN_MFHI, FN_MFLO), also used by the decoder;
  - NOP_WORD constant.
- Sub-module inst_encoder_fields: purely combinational kind/fields to {word, illegal}.
- inst_encoder holds the FSM, output register and counters.

Test Plan:
- Reset, then ADDIU rs=3 rt=5 imm=0x0010, out_ready=1 -> out_word 0x24650010 at out_addr 0; words_sent becomes 1.
- Back-to-back ADDU rd=4 rs=1 rt=2, then SW rs=29 rt=31 imm=4, with out_ready=1 -> 0x00222021 at addr 0, then 0xAFBF0004 at addr 1, in consecutive cycles.
- out_ready held low 3 cycles with MFLO rd=8 pending -> out_word stays 0x00004012, in_ready=0; DIVU rs=6 rt=7 rd=9 is then emitted as 0x00C7001A.
- Illegal kind 4'hF -> err_illegal pulses 1 cycle; out_valid stays 0; out_addr and words_sent unchanged.
- addr_load=1 with addr_val=2^AW-1 in EMPTY, then two ANDI words -> addresses 2^AW-1 then 0 (wrap).
- With INST_ENCODER_DELAY_SLOT_EN defined: BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF, then NOP 0x00000000 at the next address; in_ready=0 during PAD. Assert rst_n=0 during PAD -> out_valid=0 next cycle and the pad is dropped.

Source files
------------

// File: rtl/leg_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : leg_isa_pkg
//  Brief    : Instruction kinds, opcode/funct codes and NOP word shared by the
//             instruction encoder and decoder.
//  Revision : 1.0  initial release
// ============================================================================
package leg_isa_pkg;

    typedef enum logic [3:0] {
        K_ADDIU = 4'd0,
        K_ANDI  = 4'd1,
        K_BEQ   = 4'd2,
        K_LW    = 4'd3,
        K_SW    = 4'd4,
        K_ADDU  = 4'd5,
        K_AND   = 4'd6,
        K_DIVU  = 4'd7,
        K_MFHI  = 4'd8,
        K_MFLO  = 4'd9
    } kind_t;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_DIVU  = 6'b011010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/inst_encoder_fields.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder_fields
//  Brief    : Combinational mapping of instruction kind and register/immediate
//             fields to a 32-bit MIPS-subset word plus an illegal-kind flag.
//  Revision : 1.0  initial release
// ============================================================================
module inst_encoder_fields
    import leg_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Unused fields are zeroed; shamt is always zero.
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (kind)
            K_ADDIU: word = {OP_ADDIU, rs, rt, imm};
            K_ANDI:  word = {OP_ANDI,  rs, rt, imm};
            K_BEQ:   word = {OP_BEQ,   rs, rt, imm};
            K_LW:    word = {OP_LW,    rs, rt, imm};
            K_SW:    word = {OP_SW,    rs, rt, imm};
            K_ADDU:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
            K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            K_DIVU:  word = {OP_RTYPE, rs, rt, 5'd0, 5'd0, FN_DIVU};
            K_MFHI:  word = {OP_RTYPE, 5'd0, 5'd0, rd, 5'd0, FN_MFHI};
            K_MFLO:  word = {OP_RTYPE, 5'd0, 5'd0, rd, 5'd0, FN_MFLO};
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Brief    : Field-level instruction requests in, encoded words with an
//             auto-incrementing imem address out (single-entry output stage).
//             Optional macro INST_ENCODER_DELAY_SLOT_EN appends a NOP after
//             every transferred BEQ.
//  Revision : 1.0  initial release
// ============================================================================
module inst_encoder
    import leg_isa_pkg::*;
#(
    parameter int          AW   = 10,
    parameter int unsigned BASE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [AW-1:0] out_addr,
    output logic          err_illegal,
    output logic [AW-1:0] words_sent
);

`ifdef INST_ENCODER_DELAY_SLOT_EN
    localparam logic c_ds_en = 1'b1;
`else
    localparam logic c_ds_en = 1'b0;
`endif

    localparam logic [AW-1:0] c_base = AW'(BASE);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_word;
    logic [31:0]   w_word_nxt;
    logic          r_is_beq;
    logic          w_is_beq_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [AW-1:0] r_words_sent;
    logic          r_err;

    logic [31:0]   w_enc_word;
    logic          w_enc_illegal;
    logic          w_pad_pending;
    logic          w_accept;
    logic          w_load;
    logic          w_xfer;

    inst_encoder_fields u_fields (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (w_enc_word),
        .illegal (w_enc_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_word       <= '0;
            r_is_beq     <= 1'b0;
            r_addr       <= c_base;
            r_words_sent <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_word   <= w_word_nxt;
            r_is_beq <= w_is_beq_nxt;
            r_addr   <= w_addr_nxt;
            r_err    <= w_accept && w_enc_illegal;
            if (w_xfer) begin
                r_words_sent <= r_words_sent + 1'b1;
            end
        end
    end

    always_comb begin
        // A BEQ held in FULL must not admit a new word: its NOP follows it.
        w_pad_pending = c_ds_en && r_is_beq;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            ST_EMPTY: in_ready = 1'b1;
            ST_FULL: begin
                in_ready  = out_ready && !w_pad_pending;
                out_valid = 1'b1;
            end
            ST_PAD:   out_valid = 1'b1;
            default: ;
        endcase

        w_accept = in_valid && in_ready;
        w_load   = w_accept && !w_enc_illegal;
        w_xfer   = out_valid && out_ready;

        w_state_nxt  = r_state;
        w_word_nxt   = r_word;
        w_is_beq_nxt = r_is_beq;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_nxt  = ST_FULL;
                    w_word_nxt   = w_enc_word;
                    w_is_beq_nxt = (in_kind == K_BEQ);
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    if (w_pad_pending) begin
                        w_state_nxt  = ST_PAD;
                        w_word_nxt   = NOP_WORD;
                        w_is_beq_nxt = 1'b0;
                    end else if (w_load) begin
                        w_word_nxt   = w_enc_word;
                        w_is_beq_nxt = (in_kind == K_BEQ);
                    end else begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
            end
            ST_PAD: begin
                if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        w_addr_nxt = r_addr;
        if (w_xfer) begin
            w_addr_nxt = r_addr + 1'b1;
        end else if (r_state == ST_EMPTY && addr_load) begin
            w_addr_nxt = addr_val;
        end
    end

    assign out_word    = r_word;
    assign out_addr    = r_addr;
    assign err_illegal = r_err;
    assign words_sent  = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_inst_encoder
//  Brief    : Directed and randomized bench for inst_encoder against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_encoder;
    import leg_isa_pkg::*;

    localparam int          AW   = 10;
    localparam int unsigned BASE = 0;
`ifdef INST_ENCODER_DELAY_SLOT_EN
    localparam bit c_ds = 1'b1;
`else
    localparam bit c_ds = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_kind;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic          addr_load;
    logic [AW-1:0] addr_val;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic [AW-1:0] out_addr;
    logic          err_illegal;
    logic [AW-1:0] words_sent;

    always #5 clk = ~clk;

    inst_encoder #(.AW(AW), .BASE(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .addr_load   (addr_load),
        .addr_val    (addr_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .words_sent  (words_sent)
    );

    // Reference model: queue of words still to be emitted, in order.
    typedef struct packed {
        logic [31:0] word;
        logic        pad;
    } ent_t;

    ent_t          m_q[$];
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_sent;
    logic          m_err;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {illegal, word}, built from opcode/funct numbers directly.
    function automatic logic [32:0] ref_encode(input logic [3:0] k, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [15:0] imm);
        logic [31:0] i_part;
        logic [31:0] r_part;
        i_part = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        r_part = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        case (k)
            K_ADDIU: return {1'b0, (32'd9  << 26) | i_part};
            K_ANDI:  return {1'b0, (32'd12 << 26) | i_part};
            K_BEQ:   return {1'b0, (32'd4  << 26) | i_part};
            K_LW:    return {1'b0, (32'd35 << 26) | i_part};
            K_SW:    return {1'b0, (32'd43 << 26) | i_part};
            K_ADDU:  return {1'b0, r_part | 32'd33};
            K_AND:   return {1'b0, r_part | 32'd36};
            K_DIVU:  return {1'b0, (32'(rs) << 21) | (32'(rt) << 16) | 32'd26};
            K_MFHI:  return {1'b0, (32'(rd) << 11) | 32'd16};
            K_MFLO:  return {1'b0, (32'(rd) << 11) | 32'd18};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // One clock: check DUT against model at negedge, advance model at posedge.
    task automatic step();
        logic [32:0] enc;
        bit          exp_valid;
        bit          exp_ready;
        bit          was_empty;
        bit          xfer;
        bit          acc;
        ent_t        e;
        @(negedge clk);
        was_empty = (m_q.size() == 0);
        exp_valid = !was_empty;
        exp_ready = was_empty || (m_q.size() == 1 && out_ready && !m_q[0].pad);
        check_eq("out_valid",   32'(out_valid),   32'(exp_valid));
        check_eq("in_ready",    32'(in_ready),    32'(exp_ready));
        check_eq("err_illegal", 32'(err_illegal), 32'(m_err));
        check_eq("words_sent",  32'(words_sent),  32'(m_sent));
        check_eq("out_addr",    32'(out_addr),    32'(m_addr));
        if (exp_valid) check_eq("out_word", out_word, m_q[0].word);
        xfer = exp_valid && out_ready;
        acc  = in_valid && exp_ready;
        enc  = ref_encode(in_kind, in_rs, in_rt, in_rd, in_imm);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_addr = AW'(BASE);
            m_sent = '0;
            m_err  = 1'b0;
        end else begin
            if (xfer) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 1'b1;
                m_sent = m_sent + 1'b1;
            end else if (was_empty && addr_load) begin
                m_addr = addr_val;
            end
            m_err = acc && enc[32];
            if (acc && !enc[32]) begin
                e.word = enc[31:0];
                e.pad  = 1'b0;
                m_q.push_back(e);
                if (c_ds && in_kind == K_BEQ) begin
                    e.word = 32'd0;
                    e.pad  = 1'b1;
                    m_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm);
        in_valid = 1'b1;
        in_kind  = k;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        addr_load = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; addr_load = 1'b0; addr_val = '0; out_ready = 1'b1;
        m_addr = AW'(BASE); m_sent = '0; m_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_word", out_word, 32'h0);

        set_req(K_ADDIU, 5'd3, 5'd5, 5'd0, 16'h0010);
        step();
        in_valid = 1'b0;
        check_eq("addiu_word", out_word, 32'h2465_0010);
        check_eq("addiu_addr", 32'(out_addr), 32'd0);
        step();
        check_eq("addiu_sent", 32'(words_sent), 32'd1);

        do_reset();
        set_req(K_ADDU, 5'd1, 5'd2, 5'd4, 16'h0);
        step();
        check_eq("addu_word", out_word, 32'h0022_2021);
        check_eq("addu_addr", 32'(out_addr), 32'd0);
        set_req(K_SW, 5'd29, 5'd31, 5'd0, 16'h0004);
        step();
        in_valid = 1'b0;
        check_eq("sw_word", out_word, 32'hAFBF_0004);
        check_eq("sw_addr", 32'(out_addr), 32'd1);
        step();

        do_reset();
        set_req(K_MFLO, 5'd17, 5'd18, 5'd8, 16'hFFFF);
        out_ready = 1'b0;
        step();
        set_req(K_DIVU, 5'd6, 5'd7, 5'd9, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mflo_hold", out_word, 32'h0000_4012);
            check_eq("mflo_stall", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("divu_word", out_word, 32'h00C7_001A);
        step();

        do_reset();
        set_req(4'hF, 5'd1, 5'd1, 5'd1, 16'h1);
        step();
        in_valid = 1'b0;
        check_eq("ill_pulse", 32'(err_illegal), 32'd1);
        check_eq("ill_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("ill_clear", 32'(err_illegal), 32'd0);
        check_eq("ill_addr", 32'(out_addr), 32'd0);

        do_reset();
        addr_load = 1'b1;
        addr_val  = '1;
        step();
        addr_load = 1'b0;
        set_req(K_ANDI, 5'd2, 5'd3, 5'd0, 16'h00FF);
        step();
        check_eq("wrap_addr_hi", 32'(out_addr), 32'((1 << AW) - 1));
        step();
        in_valid = 1'b0;
        check_eq("wrap_addr_lo", 32'(out_addr), 32'd0);
        step();

`ifdef INST_ENCODER_DELAY_SLOT_EN
        do_reset();
        set_req(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        step();
        in_valid = 1'b0;
        check_eq("beq_word", out_word, 32'h1022_FFFF);
        step();
        check_eq("pad_word", out_word, 32'h0);
        check_eq("pad_addr", 32'(out_addr), 32'd1);
        check_eq("pad_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("pad_drop", 32'(out_valid), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_kind   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_load = ($urandom_range(0, 7) == 0);
            addr_val  = AW'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
